// File: rtl/stream_fifo_pkg.sv
// Shared definitions for the stream FIFO: read-mode constants, the status-flag bundle
// and a helper that turns a fill level into status flags.
package stream_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;  // standard registered read
    localparam int FIFO_MODE_FWFT = 1;  // first-word-fall-through (show-ahead)

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // All status flags come from the registered level, so they move on the same edge.
    function automatic fifo_flags_t derive_flags(input int lvl, input int depth,
                                                 input int afull_th, input int aempty_th);
        fifo_flags_t f;
        f.empty        = (lvl == 0);
        f.full         = (lvl == depth);
        f.almost_full  = (lvl >= afull_th);
        f.almost_empty = (lvl <= aempty_th);
        return f;
    endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Stream FIFO bus: flush, write/read handshakes and all status outputs.
// The producer/consumer side uses the master modport, the FIFO uses the slave modport.
interface stream_fifo_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              clr;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, empty, full, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, empty, full, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/stream_fifo_sdp_ram.sv
// Simple dual-port RAM for the FIFO storage: one synchronous write port and one
// synchronous read port. A read of an address written on the same edge returns the old word.
module stream_fifo_sdp_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage write and registered read.
    // NOTE: the array has no reset so it maps onto block RAM; stale words are never
    // exposed because the pointers and level are what get reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/stream_fifo.sv
// Single-clock stream FIFO with FWFT or standard read mode, fill level, programmable
// almost-full/almost-empty thresholds, write-through-when-full, sticky error flags
// and a synchronous flush.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int FWFT      = FIFO_MODE_FWFT,
    parameter int AFULL_TH  = 2**ADDR_W - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    stream_fifo_if.slave fifo_if
);
    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    fifo_flags_t       flags;
    logic              rd_acc, wr_acc;
    logic              rd_fire, wr_fire;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_q;

    assign flags = derive_flags(32'(level_q), DEPTH, AFULL_TH, AEMPTY_TH);

    // A read is taken only when data exists; a write is taken when there is room
    // or when a read frees a slot on the same edge (write-through when full).
    assign rd_acc  = fifo_if.rd_en & ~flags.empty;
    assign wr_acc  = fifo_if.wr_en & (~flags.full | rd_acc);
    // Flush overrides both handshakes.
    assign rd_fire = rd_acc & ~fifo_if.clr;
    assign wr_fire = wr_acc & ~fifo_if.clr;

    // Next-state for pointers, level and sticky error flags.
    // NOTE: every variable gets a default at the top, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (fifo_if.clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + CNT_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + CNT_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + CNT_ONE;
                2'b01:   level_d = level_q - CNT_ONE;
                default: level_d = level_q;
            endcase
            if (fifo_if.wr_en && !wr_acc) overflow_d  = 1'b1;
            if (fifo_if.rd_en && !rd_acc) underflow_d = 1'b1;
        end
    end

    // Pointer, level and error-flag registers with synchronous active-low reset.
    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    stream_fifo_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_fire & rst_n),
        .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
        .wr_data_i (fifo_if.wr_data),
        .rd_addr_i (ram_rd_addr),
        .rd_data_o (ram_q)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Show-ahead: the RAM always looks up the head position valid after this edge.
        // When that position is being written on the same edge the RAM would return
        // the old word, so the incoming word is captured in a head register instead.
        logic              byp_q;
        logic              byp_d;
        logic [DATA_W-1:0] byp_data_q;

        assign ram_rd_addr = rd_ptr_d[ADDR_W-1:0];
        assign byp_d       = wr_fire && (wr_ptr_q == rd_ptr_d);

        // Head register: selects the just-written word when it becomes the head.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                byp_q      <= 1'b1;
                byp_data_q <= '0;
            end else if (fifo_if.clr) begin
                byp_q      <= 1'b0;
            end else begin
                byp_q <= byp_d;
                if (byp_d) byp_data_q <= fifo_if.wr_data;
            end
        end

        assign fifo_if.rd_data  = byp_q ? byp_data_q : ram_q;
        assign fifo_if.rd_valid = ~flags.empty;
    end else begin : g_std
        // Standard read: the popped word leaves the RAM one edge after the accepted
        // read and is presented, with rd_valid, one edge later.
        logic              pop_q;
        logic              rd_valid_q;
        logic [DATA_W-1:0] rd_data_q;

        assign ram_rd_addr = rd_ptr_q[ADDR_W-1:0];

        // Read pipeline: pop marker, then output register holding the last word.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pop_q      <= 1'b0;
                rd_valid_q <= 1'b0;
                rd_data_q  <= '0;
            end else if (fifo_if.clr) begin
                pop_q      <= 1'b0;
                rd_valid_q <= 1'b0;
            end else begin
                pop_q      <= rd_fire;
                rd_valid_q <= pop_q;
                if (pop_q) rd_data_q <= ram_q;
            end
        end

        assign fifo_if.rd_data  = rd_data_q;
        assign fifo_if.rd_valid = rd_valid_q;
    end

    assign fifo_if.empty        = flags.empty;
    assign fifo_if.full         = flags.full;
    assign fifo_if.almost_full  = flags.almost_full;
    assign fifo_if.almost_empty = flags.almost_empty;
    assign fifo_if.level        = level_q;
    assign fifo_if.overflow     = overflow_q;
    assign fifo_if.underflow    = underflow_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Testbench for stream_fifo: one FWFT and one standard-mode instance driven with the
// same stimulus and compared every cycle against a queue-based reference model.
module tb_stream_fifo;
    import stream_fifo_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 12;
    localparam int AEMPTY = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stream_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_fw ();
    stream_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_sd ();

    stream_fifo #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWFT(FIFO_MODE_FWFT),
        .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY)
    ) dut_fwft (
        .clk     (clk),
        .rst_n   (rst_n),
        .fifo_if (if_fw.slave)
    );

    stream_fifo #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWFT(FIFO_MODE_STD),
        .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY)
    ) dut_std (
        .clk     (clk),
        .rst_n   (rst_n),
        .fifo_if (if_sd.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: stored words in order, sticky flags, and the two-stage
    // standard-mode read pipeline (pending pop, then presented word).
    logic [DATA_W-1:0] mq[$];
    bit                m_ovf, m_udf;
    bit                m_pend, m_sv;
    logic [DATA_W-1:0] m_pend_d, m_sd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit c, input bit w,
                                input logic [DATA_W-1:0] d, input bit rd);
        bit rd_ok, wr_ok;
        if (!r) begin
            mq.delete();
            m_ovf = 0; m_udf = 0; m_pend = 0; m_sv = 0; m_sd = '0;
        end else if (c) begin
            mq.delete();
            m_ovf = 0; m_udf = 0; m_pend = 0; m_sv = 0;
        end else begin
            rd_ok = rd && (mq.size() > 0);
            wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
            m_sv = m_pend;
            if (m_pend) m_sd = m_pend_d;
            m_pend = rd_ok;
            if (rd_ok) m_pend_d = mq.pop_front();
            if (wr_ok) mq.push_back(d);
            if (w && !wr_ok) m_ovf = 1;
            if (rd && !rd_ok) m_udf = 1;
        end
    endtask

    task automatic check_status(input string who, input logic [ADDR_W:0] lvl,
                                input logic e, input logic f, input logic af,
                                input logic ae, input logic ov, input logic ud);
        int n = mq.size();
        check({who, " level"},        32'(lvl), 32'(n));
        check({who, " empty"},        32'(e),   32'(n == 0));
        check({who, " full"},         32'(f),   32'(n == DEPTH));
        check({who, " almost_full"},  32'(af),  32'(n >= AFULL));
        check({who, " almost_empty"}, 32'(ae),  32'(n <= AEMPTY));
        check({who, " overflow"},     32'(ov),  32'(m_ovf));
        check({who, " underflow"},    32'(ud),  32'(m_udf));
    endtask

    task automatic check_outputs(input bit after_rst);
        check_status("fwft", if_fw.level, if_fw.empty, if_fw.full, if_fw.almost_full,
                     if_fw.almost_empty, if_fw.overflow, if_fw.underflow);
        check_status("std", if_sd.level, if_sd.empty, if_sd.full, if_sd.almost_full,
                     if_sd.almost_empty, if_sd.overflow, if_sd.underflow);
        check("fwft rd_valid", 32'(if_fw.rd_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) check("fwft rd_data head", 32'(if_fw.rd_data), 32'(mq[0]));
        if (after_rst) check("fwft rd_data reset", 32'(if_fw.rd_data), 32'(0));
        check("std rd_valid", 32'(if_sd.rd_valid), 32'(m_sv));
        check("std rd_data",  32'(if_sd.rd_data),  32'(m_sd));
    endtask

    // One clock: drive at the falling edge, model the rising edge, sample at the next fall.
    task automatic step(input bit r, input bit c, input bit w,
                        input logic [DATA_W-1:0] d, input bit rd);
        rst_n = r;
        if_fw.clr = c; if_fw.wr_en = w; if_fw.wr_data = d; if_fw.rd_en = rd;
        if_sd.clr = c; if_sd.wr_en = w; if_sd.wr_data = d; if_sd.rd_en = rd;
        @(posedge clk);
        model_update(r, c, w, d, rd);
        @(negedge clk);
        check_outputs(!r);
    endtask

    initial begin
        int wr_p, rd_p;

        // Reset state
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 0);

        // T1: single write appears on the FWFT output with no extra latency
        step(1, 0, 1, 16'h00A1, 0);
        check("t1 fwft rd_valid", 32'(if_fw.rd_valid), 32'(1));
        check("t1 fwft rd_data",  32'(if_fw.rd_data),  32'h00A1);
        check("t1 fwft level",    32'(if_fw.level),    32'(1));
        step(1, 0, 0, '0, 1);
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);

        // T2: fill to full, rejected 17th write, drain in order
        for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 16'(16'h0100 + i), 0);
        step(1, 0, 1, 16'hDEAD, 0);
        check("t2 overflow", 32'(if_fw.overflow), 32'(1));
        check("t2 level",    32'(if_fw.level),    32'(16));
        for (int i = 0; i < DEPTH + 2; i++) step(1, 0, 0, '0, 1);

        // T3: write-through while full, 24 words drain in write order
        step(1, 1, 0, '0, 0);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 16'(16'h0200 + i), 0);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 16'(16'h0210 + i), 1);
        check("t3 level",    32'(if_fw.level),    32'(16));
        check("t3 overflow", 32'(if_sd.overflow), 32'(0));
        for (int i = 0; i < DEPTH + 2; i++) step(1, 0, 0, '0, 1);

        // T4: standard-mode read latency
        step(1, 1, 0, '0, 0);
        step(1, 0, 1, 16'h0123, 0);
        step(1, 0, 0, '0, 1);
        check("t4 std rd_valid edge n",   32'(if_sd.rd_valid), 32'(0));
        step(1, 0, 0, '0, 0);
        check("t4 std rd_valid edge n+1", 32'(if_sd.rd_valid), 32'(1));
        check("t4 std rd_data edge n+1",  32'(if_sd.rd_data),  32'h0123);
        step(1, 0, 0, '0, 0);
        check("t4 std rd_valid edge n+2", 32'(if_sd.rd_valid), 32'(0));

        // T5: underflow on empty read, then flush ignores concurrent write
        step(1, 0, 0, '0, 1);
        check("t5 underflow", 32'(if_fw.underflow), 32'(1));
        step(1, 0, 1, 16'h0055, 1);
        step(1, 1, 1, 16'h0077, 0);
        check("t5 clr level",     32'(if_sd.level),     32'(0));
        check("t5 clr underflow", 32'(if_sd.underflow), 32'(0));
        step(1, 0, 0, '0, 0);

        // T6: random traffic with a mid-run reset and occasional flushes
        wr_p = 60; rd_p = 40;
        for (int i = 0; i < 1000; i++) begin
            if (i % 100 == 0) begin
                wr_p = $urandom_range(20, 90);
                rd_p = $urandom_range(20, 90);
            end
            if (i == 500) begin
                step(0, 0, 1, 16'($urandom), 1);
            end else begin
                step(1, ($urandom_range(0, 63) == 0),
                     ($urandom_range(0, 99) < wr_p), 16'($urandom),
                     ($urandom_range(0, 99) < rd_p));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
